// File: rtl/ram_port_arbiter.sv
// Two-port arbiter sharing one single-port RAM: round-robin with a port-B burst lock,
// one-cycle tagged read return. Optional saturating conflict counter: ARB_CONFLICT_COUNT_EN.
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_stall,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en_read,
    output logic              ram_en_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflict_count
);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t            last_owner;
    owner_t            pend_owner;
    logic              lock;
    logic              pend_valid;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              a_win;
    logic              b_win;
    logic              a_ret;
    logic              b_ret;

    // Outputs are forced to their reset values while reset is high, so a read
    // return landing in a reset cycle is dropped rather than delivered.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (!reset) begin
            if (lock && b_req) begin
                b_win = 1'b1;
            end else if (a_req && b_req) begin
                if (last_owner == OWNER_B) a_win = 1'b1;
                else                       b_win = 1'b1;
            end else if (a_req) begin
                a_win = 1'b1;
            end else if (b_req) begin
                b_win = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en_read  = 1'b0;
        ram_en_write = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        if (a_win) begin
            ram_en_read  = ~a_we;
            ram_en_write = a_we;
            ram_addr     = a_addr;
            ram_wdata    = a_wdata;
        end else if (b_win) begin
            ram_en_read  = ~b_we;
            ram_en_write = b_we;
            ram_addr     = b_addr;
            ram_wdata    = b_wdata;
        end
    end

    assign a_gnt    = a_win;
    assign b_gnt    = b_win;
    assign a_stall  = ~reset & a_req & ~a_win;

    assign a_ret    = ~reset & pend_valid & (pend_owner == OWNER_A);
    assign b_ret    = ~reset & pend_valid & (pend_owner == OWNER_B);
    assign a_rvalid = a_ret;
    assign b_rvalid = b_ret;
    assign a_rdata  = reset ? '0 : (a_ret ? ram_rdata : a_rdata_q);
    assign b_rdata  = reset ? '0 : (b_ret ? ram_rdata : b_rdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWNER_B;
            pend_owner <= OWNER_A;
            pend_valid <= 1'b0;
            lock       <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            if (a_ret) a_rdata_q <= ram_rdata;
            if (b_ret) b_rdata_q <= ram_rdata;
            pend_valid <= (a_win & ~a_we) | (b_win & ~b_we);
            pend_owner <= b_win ? OWNER_B : OWNER_A;
            if (a_win)      last_owner <= OWNER_A;
            else if (b_win) last_owner <= OWNER_B;
            lock <= b_win & b_lock;
        end
    end

`ifdef ARB_CONFLICT_COUNT_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (a_req && b_req && conflict_q != '1) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, rule-level arbiter model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        ram_en_read, ram_en_write;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [15:0] conflict_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_en_read(ram_en_read), .ram_en_write(ram_en_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // RAM: registered read, one cycle latency
    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 257);
            shadow[i] = 16'(i * 257);
        end
        mem[8'h10]    = 16'hBEEF;
        shadow[8'h10] = 16'hBEEF;
    end
    always @(posedge clk) begin
        if (ram_en_write) mem[ram_addr] <= ram_wdata;
        if (ram_en_read)  ram_rdata <= mem[ram_addr];
    end

    // Model state: who served last, whether B holds a burst, pending return
    bit          m_last_b, m_locked;
    bit          m_ret_a, m_ret_b;
    logic [15:0] m_ret_d, m_a_last, m_b_last;
    int unsigned m_conf;
    bit          win_a, win_b;

    always @(negedge clk) begin
        logic [7:0]  e_addr;
        logic [15:0] e_wdata;
        bit          e_rd, e_wr;
        win_a = 0; win_b = 0;
        e_addr = '0; e_wdata = '0; e_rd = 0; e_wr = 0;
        if (!reset) begin
            if (m_locked && b_req)       win_b = 1;
            else if (a_req && b_req)     begin win_a = m_last_b; win_b = !m_last_b; end
            else                         begin win_a = a_req; win_b = b_req; end
        end
        if (win_a) begin e_addr = a_addr; e_wdata = a_wdata; e_wr = a_we; e_rd = !a_we; end
        if (win_b) begin e_addr = b_addr; e_wdata = b_wdata; e_wr = b_we; e_rd = !b_we; end
        check("a_gnt", 32'(a_gnt), 32'(win_a));
        check("b_gnt", 32'(b_gnt), 32'(win_b));
        check("a_stall", 32'(a_stall), 32'(!reset && a_req && !win_a));
        check("ram_en_read", 32'(ram_en_read), 32'(e_rd));
        check("ram_en_write", 32'(ram_en_write), 32'(e_wr));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        check("a_rvalid", 32'(a_rvalid), 32'(!reset && m_ret_a));
        check("b_rvalid", 32'(b_rvalid), 32'(!reset && m_ret_b));
        check("a_rdata", 32'(a_rdata), reset ? 32'd0 : 32'(m_ret_a ? m_ret_d : m_a_last));
        check("b_rdata", 32'(b_rdata), reset ? 32'd0 : 32'(m_ret_b ? m_ret_d : m_b_last));
`ifdef ARB_CONFLICT_COUNT_EN
        check("conflict_count", 32'(conflict_count), m_conf);
`else
        check("conflict_count", 32'(conflict_count), 32'd0);
`endif
    end

    always @(posedge clk) begin
        if (reset) begin
            m_last_b <= 1; m_locked <= 0; m_ret_a <= 0; m_ret_b <= 0;
            m_ret_d <= '0; m_a_last <= '0; m_b_last <= '0; m_conf <= 0;
        end else begin
            if (m_ret_a) m_a_last <= m_ret_d;
            if (m_ret_b) m_b_last <= m_ret_d;
            m_ret_a <= win_a && !a_we;
            m_ret_b <= win_b && !b_we;
            if (win_a) begin
                m_ret_d <= shadow[a_addr];
                if (a_we) shadow[a_addr] <= a_wdata;
            end
            if (win_b) begin
                m_ret_d <= shadow[b_addr];
                if (b_we) shadow[b_addr] <= b_wdata;
            end
            if (win_a || win_b) m_last_b <= win_b;
            m_locked <= win_b && b_lock;
            if (a_req && b_req && m_conf < 32'hFFFF) m_conf <= m_conf + 1;
        end
    end

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    endtask
    task automatic set_a(input logic r, input logic w, input logic [7:0] ad, input logic [15:0] d);
        a_req = r; a_we = w; a_addr = ad; a_wdata = d;
    endtask
    task automatic set_b(input logic r, input logic w, input logic [7:0] ad, input logic [15:0] d,
                         input logic l);
        b_req = r; b_we = w; b_addr = ad; b_wdata = d; b_lock = l;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic do_reset();
        reset = 1; idle(); tick(); reset = 0;
    endtask

    initial begin
        reset = 1; idle();
        tick(); tick();
        @(negedge clk);
        check("lit reset a_gnt", 32'(a_gnt), 32'd0);
        check("lit reset ram_en_read", 32'(ram_en_read), 32'd0);
        tick(); reset = 0;

        // single A read of BEEF
        set_a(1, 0, 8'h10, '0);
        @(negedge clk);
        check("lit a_gnt", 32'(a_gnt), 32'd1);
        check("lit ram_en_read", 32'(ram_en_read), 32'd1);
        check("lit ram_addr", 32'(ram_addr), 32'h10);
        tick(); idle();
        @(negedge clk);
        check("lit a_rvalid", 32'(a_rvalid), 32'd1);
        check("lit a_rdata", 32'(a_rdata), 32'hBEEF);
        check("lit b_rvalid", 32'(b_rvalid), 32'd0);
        tick();

        // both read from reset: A first, then B
        do_reset();
        set_a(1, 0, 8'h01, '0); set_b(1, 0, 8'h02, '0, 0);
        @(negedge clk);
        check("lit first conflict a_gnt", 32'(a_gnt), 32'd1);
        check("lit first conflict a_stall", 32'(a_stall), 32'd0);
        tick(); set_a(0, 0, '0, '0);
        @(negedge clk);
        check("lit second b_gnt", 32'(b_gnt), 32'd1);
        check("lit a_rdata 0101", 32'(a_rdata), 32'h0101);
        tick(); idle();
        @(negedge clk);
        check("lit b_rvalid", 32'(b_rvalid), 32'd1);
        check("lit b_rdata 0202", 32'(b_rdata), 32'h0202);
        tick();

        // sustained conflict alternates
        do_reset();
        set_a(1, 0, 8'h03, '0); set_b(1, 0, 8'h04, '0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lit alternate a_gnt", 32'(a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        @(negedge clk);
`ifdef ARB_CONFLICT_COUNT_EN
        check("lit conflict_count", 32'(conflict_count), 32'd6);
`else
        check("lit conflict_count", 32'(conflict_count), 32'd0);
`endif
        tick();

        // A write then read back
        set_a(1, 1, 8'h05, 16'h1234);
        @(negedge clk);
        check("lit write strobe", 32'(ram_en_write), 32'd1);
        check("lit write data", 32'(ram_wdata), 32'h1234);
        tick(); set_a(1, 0, 8'h05, '0);
        @(negedge clk);
        check("lit no rvalid on write", 32'(a_rvalid), 32'd0);
        tick(); idle();
        @(negedge clk);
        check("lit readback", 32'(a_rdata), 32'h1234);
        tick();

        // B locked burst starves A
        set_a(1, 0, 8'h40, '0);
        for (int i = 0; i < 4; i++) begin
            set_b(1, 1, 8'(8'h20 + i), 16'(16'hC000 + i), 1);
            @(negedge clk);
            check("lit burst b_gnt", 32'(b_gnt), 32'd1);
            check("lit burst addr", 32'(ram_addr), 32'(8'h20 + i));
            check("lit burst a_stall", 32'(a_stall), 32'd1);
            tick();
        end
        set_b(0, 0, '0, '0, 0);
        @(negedge clk);
        check("lit a after burst", 32'(a_gnt), 32'd1);
        tick(); set_a(0, 0, '0, '0); set_b(1, 0, 8'h22, '0, 0);
        tick(); idle();
        @(negedge clk);
        check("lit burst readback", 32'(b_rdata), 32'hC002);
        tick();

        // reset during read return
        set_a(1, 0, 8'h10, '0);
        tick(); idle(); reset = 1;
        @(negedge clk);
        check("lit dropped rvalid", 32'(a_rvalid), 32'd0);
        tick(); reset = 0;
        @(negedge clk);
        check("lit rdata cleared", 32'(a_rdata), 32'd0);
        tick();
        set_a(1, 0, 8'h01, '0); set_b(1, 0, 8'h02, '0, 0);
        @(negedge clk);
        check("lit post-reset conflict", 32'(a_gnt), 32'd1);
        tick(); idle(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
